// File: rtl/alu_share_arbiter_pkg.sv
// Shared CPU data/ALU-op types and helpers for the ALU sharing arbiter.
package alu_share_arbiter_pkg;

  typedef logic [31:0] type_CpuData;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } type_AluOp;

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic {
    EMPTY,
    FULL
  } out_state_e;

  function automatic logic is_shift(input type_AluOp op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; shifts use only the low SHAMT_W bits of b.
module alu
  import alu_share_arbiter_pkg::*;
(
  input  type_AluOp   op,
  input  type_CpuData a,
  input  type_CpuData b,
  output type_CpuData y
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'b0, (a < b)};
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = type_CpuData'($signed(a) >>> shamt);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters; result lands in a one-entry register tagged with the winner.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  type_CpuData         req_a [NREQ],
  input  type_CpuData         req_b [NREQ],
  input  type_AluOp           req_op [NREQ],
  output logic [NREQ-1:0]     resp_valid,
  output type_CpuData         resp_y,
  output logic [IDW-1:0]      resp_id,
  input  logic [NREQ-1:0]     resp_ready
);

  out_state_e       state, state_d;
  logic [IDW-1:0]   rr_ptr, rr_ptr_d;
  logic [IDW-1:0]   gnt_id, resp_id_d;
  logic [NREQ-1:0]  gnt;
  type_CpuData      resp_y_d;
  type_CpuData      alu_a, alu_b, alu_y;
  type_AluOp        alu_op;
  logic             drain, can_accept, accept;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign alu_a  = req_a[gnt_id];
  assign alu_op = req_op[gnt_id];
  assign alu_b  = is_shift(req_op[gnt_id]) ? type_CpuData'(req_b[gnt_id][SHAMT_W-1:0])
                                           : req_b[gnt_id];

  alu u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Only the owner's resp_ready can drain; a drain frees the slot for a same-edge accept.
  assign drain      = (state == FULL) && resp_ready[resp_id];
  assign can_accept = (state == EMPTY) || drain;
  assign accept     = can_accept && (|req_valid) && !rst;
  assign req_ready  = accept ? gnt : '0;

  always_comb begin
    resp_valid = '0;
    if (state == FULL) resp_valid[resp_id] = 1'b1;
  end

  always_comb begin
    state_d   = state;
    resp_y_d  = resp_y;
    resp_id_d = resp_id;
    rr_ptr_d  = rr_ptr;
    if (accept) begin
      state_d   = FULL;
      resp_y_d  = alu_y;
      resp_id_d = gnt_id;
      rr_ptr_d  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      resp_y  <= '0;
      resp_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_d;
      resp_y  <= resp_y_d;
      resp_id <= resp_id_d;
      rr_ptr  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with NREQ=2 and directed vectors.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    y;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  type_CpuData     req_a [NREQ];
  type_CpuData     req_b [NREQ];
  type_AluOp       req_op [NREQ];
  logic [NREQ-1:0] resp_valid;
  type_CpuData     resp_y;
  logic [IDW-1:0]  resp_id;
  logic [NREQ-1:0] resp_ready;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] y);
    exp_t e;
    e.id = IDW'(id);
    e.y  = y;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every drain of the output register is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid != '0 && resp_ready[resp_id]) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_id), 32'hDEAD);
      end else begin
        exp_t e;
        logic [NREQ-1:0] oh;
        e  = sb.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        chk("resp_id", 32'(resp_id), 32'(e.id));
        chk("resp_y", resp_y, e.y);
        chk("resp_valid_onehot", 32'(resp_valid), 32'(oh));
      end
    end
  end

  task automatic issue(input int id, input type_AluOp op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] y);
    int n;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_a[id]     = a;
    req_b[id]     = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 20);
    if (!req_ready[id]) chk("grant_timeout", 32'(req_ready), 32'(1 << id));
    else push(id, y);
    step();
    req_valid[id] = 1'b0;
  endtask

  // Both requesters held valid; grants must alternate starting at index 0.
  task automatic contention(input int nacc);
    req_op[0] = ALU_SUB; req_a[0] = 32'd10;  req_b[0] = 32'd3;
    req_op[1] = ALU_XOR; req_a[1] = 32'hF0;  req_b[1] = 32'hFF;
    req_valid = 2'b11;
    for (int k = 0; k < nacc; k++) begin
      @(negedge clk);
      chk("contention_gnt", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k % 2 == 0) push(0, 32'd7);
      else            push(1, 32'h0F);
      step();
    end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = '0; req_b[i] = '0; req_op[i] = ALU_ADD;
    end
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_y", resp_y, 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    req_valid = '0;
    step();
    rst = 1'b0;
    step();

    contention(4);
    repeat (2) step();

    issue(0, ALU_ADD, 32'd5, 32'd7, 32'd12);
    chk("single_resp_valid", 32'(resp_valid), 32'h1);
    chk("single_resp_y", resp_y, 32'd12);
    chk("single_resp_id", 32'(resp_id), 32'h0);
    step();

    resp_ready = 2'b00;
    issue(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    req_op[1] = ALU_ADD; req_a[1] = 32'd2; req_b[1] = 32'd3;
    req_valid[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_resp_y", resp_y, 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    step();
    resp_ready = 2'b01;
    @(negedge clk);
    chk("bp_drain_accept", 32'(req_ready), 32'h2);
    push(1, 32'd5);
    step();
    req_valid[1] = 1'b0;
    resp_ready   = 2'b11;
    step();

    issue(1, ALU_SLL,  32'h1,         32'h21,        32'h2);
    issue(0, ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000);
    issue(1, ALU_SRL,  32'h8000_0000, 32'd32,        32'h8000_0000);
    issue(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0);
    issue(1, ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'h1);
    issue(0, ALU_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    step();

    // Leave a result pending with rr_ptr at 1, then reset between edges.
    resp_ready = 2'b00;
    issue(0, ALU_ADD, 32'd1, 32'd1, 32'd2);
    chk("pre_rst_resp_valid", 32'(resp_valid), 32'h1);
    req_valid = 2'b11;
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("async_rst_resp_y", resp_y, 32'h0);
    chk("async_rst_req_ready", 32'(req_ready), 32'h0);
    step();
    rst        = 1'b0;
    resp_ready = 2'b11;
    contention(2);

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
